// File: rtl/cpu_param.sv
// ---------------------------------------------------------------------------
// cpu_param
//
// Parametrised single-issue processor core. Every instruction completes in
// one clock: decode, register read, ALU and next-PC are combinational, and the
// register write plus the PC update commit together at the rising edge that
// ends the instruction. A small RUN / STALL / HALT state machine gates that
// commit.
//
// Parameters
//   DATA_W  register and ALU width (8..32)
//   REG_N   number of general registers (power of two, 2..256)
//
// Ports
//   CLK          in   1       clock, all state on the rising edge
//   RESET        in   1       synchronous, active-high reset
//   INSTRUCTION  in   32      instruction at address PC (combinational)
//   BUSYWAIT     in   1       memory stall request
//   PC           out  32      address of the current instruction
//   ILLEGAL      out  1       undefined opcode executing this cycle
//   HALTED       out  1       core is in HALT
//   DBG_ADDR     in   RA_W    debug register select
//   DBG_DATA     out  DATA_W  combinational read of register DBG_ADDR
//   DBG_STATE    out  2       current state (0 RUN, 1 STALL, 2 HALT)
//
// Stall handshake: BUSYWAIT is sampled at each rising edge. While it is high
// nothing commits (PC and registers hold, ILLEGAL is suppressed) and the same
// INSTRUCTION must be presented again; the first edge that sees it low
// executes that instruction normally. There is no separate ready/ack.
// ---------------------------------------------------------------------------
module cpu_param #(
  parameter  int DATA_W = 8,
  parameter  int REG_N  = 8,
  localparam int RA_W   = (REG_N > 1) ? $clog2(REG_N) : 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [31:0]       INSTRUCTION,
  input  logic              BUSYWAIT,
  output logic [31:0]       PC,
  output logic              ILLEGAL,
  output logic              HALTED,
  input  logic [RA_W-1:0]   DBG_ADDR,
  output logic [DATA_W-1:0] DBG_DATA,
  output logic [1:0]        DBG_STATE
);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_SLL   = 8'h08;
  localparam logic [7:0] OP_SRL   = 8'h09;
  localparam logic [7:0] OP_SRA   = 8'h0A;
  localparam logic [7:0] OP_HALT  = 8'hFF;

  // -------------------------------------------------------------------------
  // Architectural state
  // -------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_next;
  logic [31:0]        r_pc;
  logic [DATA_W-1:0]  r_regs [REG_N];

  // -------------------------------------------------------------------------
  // Decode
  // -------------------------------------------------------------------------
  logic [7:0]         w_opcode;
  logic [7:0]         w_imm8;
  logic [7:0]         w_off8;
  logic [RA_W-1:0]    w_rd_idx;
  logic [RA_W-1:0]    w_rs1_idx;
  logic [RA_W-1:0]    w_rs2_idx;
  logic [DATA_W-1:0]  w_rs1;
  logic [DATA_W-1:0]  w_rs2;
  logic [DATA_W-1:0]  w_imm_sext;
  logic signed [DATA_W-1:0] w_rs1_s;
  logic [DATA_W-1:0]  w_sra_raw;
  logic               w_shamt_big;
  logic               w_unused;

  assign w_opcode  = INSTRUCTION[31:24];
  assign w_off8    = INSTRUCTION[23:16];
  assign w_imm8    = INSTRUCTION[7:0];
  // Register indices use only the low RA_W bits of each 8-bit field.
  assign w_rd_idx  = INSTRUCTION[16 +: RA_W];
  assign w_rs1_idx = INSTRUCTION[8  +: RA_W];
  assign w_rs2_idx = INSTRUCTION[0  +: RA_W];
  // Field bits above RA_W are intentionally ignored.
  assign w_unused  = &{1'b0, INSTRUCTION};

  assign w_rs1 = r_regs[w_rs1_idx];
  assign w_rs2 = r_regs[w_rs2_idx];

  assign w_imm_sext = DATA_W'($signed(w_imm8));

  // The arithmetic shift is kept in its own signed assignment so that mixing
  // it with unsigned operands later cannot silently turn it into a logical
  // shift.
  assign w_rs1_s   = w_rs1;
  assign w_sra_raw = w_rs1_s >>> w_imm8;

  assign w_shamt_big = ({24'd0, w_imm8} >= 32'(DATA_W));

  // -------------------------------------------------------------------------
  // Next PC
  // -------------------------------------------------------------------------
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_target;

  assign w_pc_plus4  = r_pc + 32'd4;
  // Offset is a signed word count; wraps modulo 2^32 like all PC arithmetic.
  assign w_pc_target = w_pc_plus4 + {{22{w_off8[7]}}, w_off8, 2'b00};

  // -------------------------------------------------------------------------
  // Execute
  // -------------------------------------------------------------------------
  logic [DATA_W-1:0] w_alu;
  logic              w_wen;
  logic              w_legal;
  logic              w_is_halt;
  logic [31:0]       w_pc_next;
  logic              w_exec;

  always_comb begin
    w_alu     = '0;
    w_wen     = 1'b0;
    w_legal   = 1'b1;
    w_is_halt = 1'b0;
    w_pc_next = w_pc_plus4;
    case (w_opcode)
      OP_LOADI: begin
        w_alu = w_imm_sext;
        w_wen = 1'b1;
      end
      OP_MOV: begin
        w_alu = w_rs2;
        w_wen = 1'b1;
      end
      OP_ADD: begin
        w_alu = w_rs1 + w_rs2;
        w_wen = 1'b1;
      end
      OP_SUB: begin
        w_alu = w_rs1 - w_rs2;
        w_wen = 1'b1;
      end
      OP_AND: begin
        w_alu = w_rs1 & w_rs2;
        w_wen = 1'b1;
      end
      OP_OR: begin
        w_alu = w_rs1 | w_rs2;
        w_wen = 1'b1;
      end
      OP_J: begin
        w_pc_next = w_pc_target;
      end
      OP_BEQ: begin
        if (w_rs1 == w_rs2) begin
          w_pc_next = w_pc_target;
        end
      end
      OP_SLL: begin
        w_wen = 1'b1;
        if (w_shamt_big) begin
          w_alu = '0;
        end else begin
          w_alu = w_rs1 << w_imm8;
        end
      end
      OP_SRL: begin
        w_wen = 1'b1;
        if (w_shamt_big) begin
          w_alu = '0;
        end else begin
          w_alu = w_rs1 >> w_imm8;
        end
      end
      OP_SRA: begin
        w_wen = 1'b1;
        if (w_shamt_big) begin
          w_alu = {DATA_W{w_rs1[DATA_W-1]}};
        end else begin
          w_alu = w_sra_raw;
        end
      end
      OP_HALT: begin
        // PC parks on the halt instruction itself.
        w_is_halt = 1'b1;
        w_pc_next = r_pc;
      end
      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // An instruction commits at the coming edge only if no reset, no stall
  // request and the core is not halted. RUN and STALL execute identically
  // once BUSYWAIT is low.
  assign w_exec = !RESET && (r_state != S_HALT) && !BUSYWAIT;

  // -------------------------------------------------------------------------
  // State machine
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_RUN, S_STALL: begin
        if (BUSYWAIT) begin
          w_state_next = S_STALL;
        end else if (w_is_halt) begin
          w_state_next = S_HALT;
        end else begin
          w_state_next = S_RUN;
        end
      end
      S_HALT: begin
        w_state_next = S_HALT;
      end
      default: begin
        w_state_next = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // -------------------------------------------------------------------------
  // PC and register file
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc <= '0;
      for (int i = 0; i < REG_N; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_exec) begin
      r_pc <= w_pc_next;
      if (w_wen) begin
        r_regs[w_rd_idx] <= w_alu;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign PC        = r_pc;
  assign HALTED    = (r_state == S_HALT);
  assign ILLEGAL   = w_exec && !w_legal;
  assign DBG_DATA  = r_regs[DBG_ADDR];
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_cpu_param.sv
// ---------------------------------------------------------------------------
// tb_cpu_param
//
// Directed bench for cpu_param. Two cores run the same instruction stream in
// lockstep: one with DATA_W=8/REG_N=8 and one with DATA_W=16/REG_N=16, so
// width-dependent results (sign extension, wrap, shift limits) are checked
// for both. Inputs change 1 ns after the rising edge; outputs are read in
// the same window, well before the next edge.
// ---------------------------------------------------------------------------
module tb_cpu_param;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_STALL = 2'd1;
  localparam logic [1:0] ST_HALT  = 2'd2;

  // Clock / reset
  logic        clk = 1'b0;
  always #50 clk = ~clk;

  logic        rst;
  logic        busy;
  logic [31:0] instr;
  logic [3:0]  dbg_addr;

  logic [31:0] pc8, pc16;
  logic        ill8, ill16;
  logic        halt8, halt16;
  logic [7:0]  dbg_data8;
  logic [15:0] dbg_data16;
  logic [1:0]  st8, st16;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] e8 [8];

  cpu_param #(.DATA_W(8), .REG_N(8)) u_dut8 (
    .CLK         (clk),
    .RESET       (rst),
    .INSTRUCTION (instr),
    .BUSYWAIT    (busy),
    .PC          (pc8),
    .ILLEGAL     (ill8),
    .HALTED      (halt8),
    .DBG_ADDR    (dbg_addr[2:0]),
    .DBG_DATA    (dbg_data8),
    .DBG_STATE   (st8)
  );

  cpu_param #(.DATA_W(16), .REG_N(16)) u_dut16 (
    .CLK         (clk),
    .RESET       (rst),
    .INSTRUCTION (instr),
    .BUSYWAIT    (busy),
    .PC          (pc16),
    .ILLEGAL     (ill16),
    .HALTED      (halt16),
    .DBG_ADDR    (dbg_addr),
    .DBG_DATA    (dbg_data16),
    .DBG_STATE   (st16)
  );

  // Scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Driver tasks
  function automatic logic [31:0] enc(input logic [7:0] op, input logic [7:0] a,
                                      input logic [7:0] b, input logic [7:0] c);
    return {op, a, b, c};
  endfunction

  task automatic apply(input logic [31:0] ins, input logic bw);
    instr = ins;
    busy  = bw;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input logic [31:0] ins, input logic bw);
    apply(ins, bw);
    tick();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    busy  = 1'b0;
    instr = 32'd0;
    tick();
    tick();
    rst   = 1'b0;
  endtask

  task automatic chk_ctl(input string tag, input logic [31:0] exp_pc, input logic [1:0] exp_st);
    check({tag, ".pc8"},      pc8,    exp_pc);
    check({tag, ".pc16"},     pc16,   exp_pc);
    check({tag, ".state8"},   st8,    exp_st);
    check({tag, ".state16"},  st16,   exp_st);
    check({tag, ".halted8"},  halt8,  (exp_st == ST_HALT));
    check({tag, ".halted16"}, halt16, (exp_st == ST_HALT));
  endtask

  task automatic chk_ill(input string tag, input logic exp);
    check({tag, ".ill8"},  ill8,  exp);
    check({tag, ".ill16"}, ill16, exp);
  endtask

  task automatic chk_reg(input string tag, input int idx, input logic [31:0] exp16, input logic [31:0] exp8);
    dbg_addr = 4'(idx);
    #1;
    check({tag, ".r16"}, dbg_data16, exp16);
    check({tag, ".r8"},  dbg_data8,  exp8);
  endtask

  // Watchdog
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    rst      = 1'b1;
    busy     = 1'b0;
    instr    = enc(8'h3C, 8'h0, 8'h0, 8'h0);
    dbg_addr = 4'd0;

    // ---- Reset and load ------------------------------------------------
    tick();
    chk_ill("rst", 1'b0);
    busy = 1'b1;            // reset must win over a stall request
    tick();
    chk_ctl("rst", 32'd0, ST_RUN);
    chk_ill("rst2", 1'b0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("rst.reg16", dbg_data16, 32'd0);
    end
    rst = 1'b0;
    apply(enc(8'h00, 8'd3, 8'd0, 8'h7F), 1'b0);
    chk_ctl("ld0", 32'd0, ST_RUN);
    tick();
    chk_ctl("ld1", 32'd4, ST_RUN);
    step(enc(8'h00, 8'd4, 8'd0, 8'h85), 1'b0);
    chk_ctl("ld2", 32'd8, ST_RUN);
    exp_q.push_back(32'h00); exp_q.push_back(32'h00);
    exp_q.push_back(32'h00); exp_q.push_back(32'h7F);
    exp_q.push_back(32'h85); exp_q.push_back(32'h00);
    exp_q.push_back(32'h00); exp_q.push_back(32'h00);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 4'(i);
      #1;
      check("ld.reg8", dbg_data8, exp_q.pop_front());
    end
    chk_reg("ld.r3", 3, 32'h007F, 32'h7F);
    chk_reg("ld.r4", 4, 32'hFF85, 32'h85);

    // ---- Arithmetic and shifts -----------------------------------------
    do_reset();
    step(enc(8'h00, 8'd1, 8'd0, 8'hFF), 1'b0);   // loadi r1,0xFF
    step(enc(8'h00, 8'd2, 8'd0, 8'h02), 1'b0);   // loadi r2,2
    step(enc(8'h02, 8'd5, 8'd1, 8'd2),  1'b0);   // add r5,r1,r2
    step(enc(8'h03, 8'd6, 8'd2, 8'd1),  1'b0);   // sub r6,r2,r1
    step(enc(8'h0A, 8'd7, 8'd1, 8'd20), 1'b0);   // sra r7,r1,20
    step(enc(8'h08, 8'd3, 8'd2, 8'd3),  1'b0);   // sll r3,r2,3
    step(enc(8'h09, 8'd4, 8'd1, 8'd4),  1'b0);   // srl r4,r1,4
    step(enc(8'h09, 8'd0, 8'd1, 8'd15), 1'b0);   // srl r0,r1,15
    step(enc(8'h04, 8'd4, 8'd4, 8'd6),  1'b0);   // and r4,r4,r6
    step(enc(8'h05, 8'd3, 8'd3, 8'd2),  1'b0);   // or r3,r3,r2
    step(enc(8'h01, 8'd2, 8'd0, 8'd7),  1'b0);   // mov r2,r7
    chk_ctl("alu", 32'h2C, ST_RUN);
    exp_q.push_back(32'h0001); e8[0] = 32'h00;
    exp_q.push_back(32'hFFFF); e8[1] = 32'hFF;
    exp_q.push_back(32'hFFFF); e8[2] = 32'hFF;
    exp_q.push_back(32'h0012); e8[3] = 32'h12;
    exp_q.push_back(32'h0003); e8[4] = 32'h03;
    exp_q.push_back(32'h0001); e8[5] = 32'h01;
    exp_q.push_back(32'h0003); e8[6] = 32'h03;
    exp_q.push_back(32'hFFFF); e8[7] = 32'hFF;
    for (int i = 0; i < 8; i++) begin
      chk_reg("alu.reg", i, exp_q.pop_front(), e8[i]);
    end

    // ---- Branching -----------------------------------------------------
    do_reset();
    step(enc(8'h06, 8'h03, 8'd0, 8'd0), 1'b0);   // j +3 at 0
    chk_ctl("j", 32'h10, ST_RUN);
    step(enc(8'h07, 8'hFE, 8'd0, 8'd0), 1'b0);   // beq r0,r0,-2
    chk_ctl("beq.taken", 32'h0C, ST_RUN);
    step(enc(8'h00, 8'd1, 8'd0, 8'd5), 1'b0);    // loadi r1,5
    chk_ctl("br.ld", 32'h10, ST_RUN);
    step(enc(8'h07, 8'hFE, 8'd0, 8'd1), 1'b0);   // beq r0,r1,-2
    chk_ctl("beq.not", 32'h14, ST_RUN);
    chk_reg("br.r0", 0, 32'd0, 32'd0);
    chk_reg("br.r1", 1, 32'd5, 32'd5);
    do_reset();
    step(enc(8'h06, 8'hFE, 8'd0, 8'd0), 1'b0);   // j -2 at 0
    chk_ctl("j.neg", 32'hFFFF_FFFC, ST_RUN);
    step(enc(8'h00, 8'd2, 8'd0, 8'd1), 1'b0);    // loadi r2,1 wraps PC
    chk_ctl("pc.wrap", 32'h0, ST_RUN);
    chk_reg("wrap.r2", 2, 32'd1, 32'd1);
    step(enc(8'h06, 8'hFF, 8'd0, 8'd0), 1'b0);   // j -1 -> self
    chk_ctl("j.self", 32'h0, ST_RUN);

    // ---- Stall ---------------------------------------------------------
    do_reset();
    step(enc(8'h00, 8'd1, 8'd0, 8'd5), 1'b0);    // loadi r1,5
    for (int k = 0; k < 3; k++) begin
      step(enc(8'h02, 8'd1, 8'd1, 8'd1), 1'b1);  // add r1,r1,r1 stalled
      chk_ctl("stall", 32'd4, ST_STALL);
      chk_reg("stall.r1", 1, 32'd5, 32'd5);
    end
    step(enc(8'h02, 8'd1, 8'd1, 8'd1), 1'b0);
    chk_ctl("stall.rel", 32'd8, ST_RUN);
    chk_reg("stall.r1b", 1, 32'd10, 32'd10);
    step(enc(8'h06, 8'h03, 8'd0, 8'd0), 1'b1);   // j held by stall
    chk_ctl("stall.j", 32'd8, ST_STALL);
    step(enc(8'h06, 8'h03, 8'd0, 8'd0), 1'b0);
    chk_ctl("stall.jrel", 32'h18, ST_RUN);

    // ---- Illegal opcode and halt ---------------------------------------
    do_reset();
    apply(enc(8'h3C, 8'd1, 8'd1, 8'd1), 1'b1);
    chk_ill("ill.stall", 1'b0);
    tick();
    chk_ctl("ill.stall", 32'd0, ST_STALL);
    apply(enc(8'h3C, 8'd1, 8'd1, 8'd1), 1'b0);
    chk_ill("ill", 1'b1);
    tick();
    chk_ctl("ill", 32'd4, ST_RUN);
    chk_reg("ill.r1", 1, 32'd0, 32'd0);
    apply(enc(8'h00, 8'd2, 8'd0, 8'h11), 1'b0);
    chk_ill("ill.next", 1'b0);
    tick();
    chk_ctl("ill.next", 32'd8, ST_RUN);
    apply(enc(8'hFF, 8'd0, 8'd0, 8'd0), 1'b0);
    chk_ill("halt.op", 1'b0);
    tick();
    chk_ctl("halt", 32'd8, ST_HALT);
    for (int k = 0; k < 20; k++) begin
      if (k % 2 == 0) begin
        apply(enc(8'h3C, 8'd2, 8'd0, 8'd0), (k % 3 == 0));
      end else begin
        apply(enc(8'h00, 8'd2, 8'd0, 8'h33), (k % 3 == 0));
      end
      chk_ill("halt.ill", 1'b0);
      tick();
      chk_ctl("halt.hold", 32'd8, ST_HALT);
    end
    chk_reg("halt.r2", 2, 32'h11, 32'h11);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("halt.rst", 32'd0, ST_RUN);

    // ---- Reset during stall --------------------------------------------
    do_reset();
    step(enc(8'h00, 8'd3, 8'd0, 8'd7), 1'b0);    // loadi r3,7
    step(enc(8'h00, 8'd2, 8'd0, 8'd9), 1'b1);    // loadi r2,9 stalled
    chk_ctl("rs.stall", 32'd4, ST_STALL);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_ctl("rs.rst", 32'd0, ST_RUN);
    chk_reg("rs.r2", 2, 32'd0, 32'd0);
    chk_reg("rs.r3", 3, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
